// File: rtl/fb_defines.sv
// rtl/fb_defines.sv - shared constants for the Firebird hazard unit
package fb_defines;

   localparam int REG_AW = 5;
   localparam int X0     = 0;
   localparam int FWD_RF = 0;

endpackage

// File: rtl/fb_fwd_select.sv
// rtl/fb_fwd_select.sv - priority bypass select for one EX source operand
import fb_defines::*;

module fb_fwd_select #(
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = fb_defines::REG_AW,
   parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
   input  logic [REG_AW-1:0]         rs_addr_i,
   input  logic [NUM_FWD-1:0]        fwd_regwrite_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
   output logic [SEL_W-1:0]          sel_o
);

   // Walk oldest to youngest so the youngest matching stage wins.
   always_comb begin
      sel_o = SEL_W'(FWD_RF);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_regwrite_i[k]
             && (fwd_rd_i[k*REG_AW +: REG_AW] != REG_AW'(X0))
             && (fwd_rd_i[k*REG_AW +: REG_AW] == rs_addr_i)) begin
            sel_o = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/fb_hazard_scoreboard.sv
// rtl/fb_hazard_scoreboard.sv - forwarding, load-use and long-latency scoreboard hazard unit
import fb_defines::*;

module fb_hazard_scoreboard #(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = fb_defines::REG_AW,
   parameter int MAX_OUT = 4,
   parameter int SEL_W   = $clog2(NUM_FWD + 1),
   parameter int CNT_W   = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]       id_rs_addr,
   input  logic [NUM_SRC-1:0]              id_rs_used,
   input  logic [REG_AW-1:0]               id_rd,
   input  logic                            id_regwrite,
   input  logic                            id_is_long,
   input  logic                            ex_valid,
   input  logic                            ex_memread,
   input  logic                            ex_regwrite,
   input  logic [REG_AW-1:0]               ex_rd,
   input  logic [NUM_SRC*REG_AW-1:0]       ex_rs_addr,
   input  logic [NUM_FWD-1:0]              fwd_regwrite,
   input  logic [NUM_FWD*REG_AW-1:0]       fwd_rd,
   input  logic                            long_wb_valid,
   input  logic [REG_AW-1:0]               long_wb_rd,
   input  logic                            pipe_hold,
   input  logic                            flush,
   output logic [NUM_SRC*SEL_W-1:0]        fwd_sel,
   output logic                            stall,
   output logic                            bubble,
   output logic [(2**REG_AW)-1:0]          sb_pending,
   output logic [$clog2(MAX_OUT+1)-1:0]    outstanding,
   output logic                            sb_err,
   output logic [CNT_W-1:0]                stall_count
);

   localparam int NREG  = 2 ** REG_AW;
   localparam int OUT_W = $clog2(MAX_OUT + 1);

   logic [NREG-1:0]  sb_pending_q, sb_pending_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic             sb_err_q, sb_err_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic             wb_hit;
   logic [NREG-1:0]  wb_mask;
   logic [NREG-1:0]  eff_pending;
   logic             lu_match;
   logic             load_use;
   logic             raw_haz;
   logic             waw_haz;
   logic             full_haz;
   logic             stall_c;
   logic             issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fb_fwd_select #(
         .NUM_FWD (NUM_FWD),
         .REG_AW  (REG_AW),
         .SEL_W   (SEL_W)
      ) u_fwd_select (
         .rs_addr_i      (ex_rs_addr[i*REG_AW +: REG_AW]),
         .fwd_regwrite_i (fwd_regwrite),
         .fwd_rd_i       (fwd_rd),
         .sel_o          (fwd_sel[i*SEL_W +: SEL_W])
      );
   end

   // A writeback only counts when it retires a pending register; the RF is
   // write-first, so the retiring register is already readable this cycle.
   always_comb begin
      wb_hit  = long_wb_valid && (long_wb_rd != REG_AW'(X0)) && sb_pending_q[long_wb_rd];
      wb_mask = '0;
      if (wb_hit) begin
         wb_mask[long_wb_rd] = 1'b1;
      end
      eff_pending = sb_pending_q & ~wb_mask;
   end

   always_comb begin
      lu_match = 1'b0;
      raw_haz  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used[i]) begin
            if (id_rs_addr[i*REG_AW +: REG_AW] == ex_rd) begin
               lu_match = 1'b1;
            end
            if (eff_pending[id_rs_addr[i*REG_AW +: REG_AW]]) begin
               raw_haz = 1'b1;
            end
         end
      end
      load_use = id_valid && ex_valid && ex_memread && ex_regwrite
                 && (ex_rd != REG_AW'(X0)) && lu_match;
      waw_haz  = id_regwrite && (id_rd != REG_AW'(X0)) && eff_pending[id_rd];
      full_haz = id_is_long && (outstanding_q == OUT_W'(MAX_OUT)) && !wb_hit;
      stall_c  = id_valid && !flush && (load_use || raw_haz || waw_haz || full_haz);
      issue    = id_valid && !stall_c && !pipe_hold && !flush && id_is_long
                 && id_regwrite && (id_rd != REG_AW'(X0));
   end

   // Clear before set: a retire and a re-issue of one register leave it pending.
   always_comb begin
      sb_pending_d = sb_pending_q & ~wb_mask;
      if (issue) begin
         sb_pending_d[id_rd] = 1'b1;
      end
      outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(wb_hit);
      sb_err_d      = sb_err_q | (long_wb_valid && !wb_hit);
      stall_count_d = stall_count_q;
      if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_pending_q  <= '0;
         outstanding_q <= '0;
         sb_err_q      <= 1'b0;
         stall_count_q <= '0;
      end else begin
         sb_pending_q  <= sb_pending_d;
         outstanding_q <= outstanding_d;
         sb_err_q      <= sb_err_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall       = stall_c;
   assign bubble      = stall_c;
   assign sb_pending  = sb_pending_q;
   assign outstanding = outstanding_q;
   assign sb_err      = sb_err_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fb_hazard_scoreboard.sv
// tb/tb_fb_hazard_scoreboard.sv - scoreboard bench for fb_hazard_scoreboard
module tb_fb_hazard_scoreboard;

   localparam int NS = 2;
   localparam int NF = 2;
   localparam int AW = 5;
   localparam int MO = 4;
   localparam int SW = 2;
   localparam int OW = 3;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic clk = 1'b0;
   logic rst;
   logic id_valid;
   logic [NS*AW-1:0] id_rs_addr;
   logic [NS-1:0] id_rs_used;
   logic [AW-1:0] id_rd;
   logic id_regwrite, id_is_long;
   logic ex_valid, ex_memread, ex_regwrite;
   logic [AW-1:0] ex_rd;
   logic [NS*AW-1:0] ex_rs_addr;
   logic [NF-1:0] fwd_regwrite;
   logic [NF*AW-1:0] fwd_rd;
   logic long_wb_valid;
   logic [AW-1:0] long_wb_rd;
   logic pipe_hold, flush;
   logic [NS*SW-1:0] fwd_sel;
   logic stall, bubble;
   logic [31:0] sb_pending;
   logic [OW-1:0] outstanding;
   logic sb_err;
   logic [CW-1:0] stall_count;

   fb_hazard_scoreboard #(
      .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW), .MAX_OUT(MO), .SEL_W(SW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_is_long(id_is_long), .ex_valid(ex_valid), .ex_memread(ex_memread),
      .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_rs_addr(ex_rs_addr),
      .fwd_regwrite(fwd_regwrite), .fwd_rd(fwd_rd), .long_wb_valid(long_wb_valid),
      .long_wb_rd(long_wb_rd), .pipe_hold(pipe_hold), .flush(flush),
      .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .sb_pending(sb_pending),
      .outstanding(outstanding), .sb_err(sb_err), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NS*SW-1:0] fsel;
      logic             stl;
      logic [31:0]      pend;
      int               outs;
      logic             err;
      int               cnt;
   } exp_t;

   exp_t exp_q[$];
   int errors = 0;
   int checks = 0;

   // Reference state: which registers await a long result, and counters.
   bit m_pend[32];
   int m_outs = 0;
   bit m_err = 1'b0;
   int m_cnt = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("fwd_sel", 64'(fwd_sel), 64'(e.fsel));
         chk("stall", 64'(stall), 64'(e.stl));
         chk("bubble", 64'(bubble), 64'(e.stl));
         chk("sb_pending", 64'(sb_pending), 64'(e.pend));
         chk("outstanding", 64'(outstanding), 64'(e.outs));
         chk("sb_err", 64'(sb_err), 64'(e.err));
         chk("stall_count", 64'(stall_count), 64'(e.cnt));
      end
   end

   task automatic idle();
      rst = 0; id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd = '0;
      id_regwrite = 0; id_is_long = 0; ex_valid = 0; ex_memread = 0;
      ex_regwrite = 0; ex_rd = '0; ex_rs_addr = '0; fwd_regwrite = '0;
      fwd_rd = '0; long_wb_valid = 0; long_wb_rd = '0; pipe_hold = 0; flush = 0;
   endtask

   function automatic int rs_of(input int i);
      return int'(id_rs_addr[i*AW +: AW]);
   endfunction

   // Predict this cycle's outputs from the rules, queue them, then advance the model.
   task automatic step();
      exp_t e;
      bit hit, lu, raw, waw, full, stl, iss;
      int wr, r, sel;
      wr  = int'(long_wb_rd);
      hit = long_wb_valid && wr != 0 && m_pend[wr];
      for (int i = 0; i < NS; i++) begin
         sel = 0;
         for (int k = 0; k < NF; k++) begin
            if (sel == 0 && fwd_regwrite[k] && fwd_rd[k*AW +: AW] != 0
                && fwd_rd[k*AW +: AW] == ex_rs_addr[i*AW +: AW]) sel = k + 1;
         end
         e.fsel[i*SW +: SW] = SW'(sel);
      end
      lu = 0; raw = 0;
      for (int i = 0; i < NS; i++) begin
         if (id_rs_used[i]) begin
            r = rs_of(i);
            if (r == int'(ex_rd)) lu = 1;
            if (m_pend[r] && !(hit && r == wr)) raw = 1;
         end
      end
      lu   = lu && id_valid && ex_valid && ex_memread && ex_regwrite && ex_rd != 0;
      waw  = id_regwrite && id_rd != 0 && m_pend[id_rd] && !(hit && int'(id_rd) == wr);
      full = id_is_long && m_outs == MO && !hit;
      stl  = id_valid && !flush && (lu || raw || waw || full);
      iss  = id_valid && !stl && !pipe_hold && !flush && id_is_long && id_regwrite && id_rd != 0;
      e.stl = stl;
      for (int j = 0; j < 32; j++) e.pend[j] = m_pend[j];
      e.outs = m_outs; e.err = m_err; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         for (int j = 0; j < 32; j++) m_pend[j] = 0;
         m_outs = 0; m_err = 0; m_cnt = 0;
      end else begin
         if (hit) begin m_pend[wr] = 0; m_outs--; end
         else if (long_wb_valid) m_err = 1;
         if (iss) begin m_pend[id_rd] = 1; m_outs++; end
         if (stl && m_cnt < CMAX) m_cnt++;
      end
      #1;
   endtask

   task automatic long_op(input int rd);
      idle(); id_valid = 1; id_is_long = 1; id_regwrite = 1; id_rd = AW'(rd);
   endtask

   task automatic random_cycle();
      int cand[$];
      idle();
      id_valid    = $urandom_range(0, 3) != 0;
      id_rs_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      id_rs_used  = NS'($urandom_range(0, 3));
      id_rd       = AW'($urandom_range(0, 7));
      id_regwrite = $urandom_range(0, 3) != 0;
      id_is_long  = $urandom_range(0, 2) == 0;
      ex_valid    = $urandom_range(0, 1);
      ex_memread  = $urandom_range(0, 2) == 0;
      ex_regwrite = $urandom_range(0, 1);
      ex_rd       = AW'($urandom_range(0, 7));
      ex_rs_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      fwd_regwrite = NF'($urandom_range(0, 3));
      fwd_rd      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      pipe_hold   = $urandom_range(0, 7) == 0;
      flush       = $urandom_range(0, 9) == 0;
      rst         = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 2) == 0) begin
         long_wb_valid = 1;
         for (int j = 1; j < 32; j++) if (m_pend[j]) cand.push_back(j);
         if (cand.size() > 0 && $urandom_range(0, 9) != 0)
            long_wb_rd = AW'(cand[$urandom_range(0, cand.size() - 1)]);
         else
            long_wb_rd = AW'($urandom_range(0, 31));
      end
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      idle(); step();

      // forwarding priority
      idle(); fwd_regwrite = 2'b11; fwd_rd = {5'd5, 5'd5}; ex_rs_addr = {5'd0, 5'd5}; step();
      fwd_regwrite = 2'b10; step();
      fwd_regwrite = 2'b11; ex_rs_addr = '0; fwd_rd = '0; step();

      // load-use
      idle(); id_valid = 1; ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7;
      id_rs_addr = {5'd7, 5'd1}; id_rs_used = 2'b11; step();
      id_rs_used = 2'b01; step();

      // long op RAW then retire
      long_op(9); step();
      idle(); id_valid = 1; id_rs_addr = {5'd0, 5'd9}; id_rs_used = 2'b01; step();
      long_wb_valid = 1; long_wb_rd = 5'd9; step();
      idle(); step();

      // same-cycle retire and re-issue
      long_op(3); step();
      long_op(3); long_wb_valid = 1; long_wb_rd = 5'd3; step();
      idle(); step();

      // full, WAW and bad writeback
      idle(); rst = 1; step();
      for (int r = 1; r <= 4; r++) begin long_op(r); step(); end
      long_op(5); step();
      idle(); id_valid = 1; id_regwrite = 1; id_rd = 5'd2; step();
      idle(); long_wb_valid = 1; long_wb_rd = 5'd20; step();
      idle(); rst = 1; step();
      idle(); step();

      // stall counter saturation
      idle(); id_valid = 1; ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd4;
      id_rs_addr = {5'd0, 5'd4}; id_rs_used = 2'b01;
      repeat (20) step();
      idle(); rst = 1; step();

      for (int n = 0; n < 3000; n++) begin
         random_cycle();
         step();
      end
      idle();

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
